// File: rtl/star_rr_arb.sv
// star_rr_arb: round-robin arbiter merging N_IN valid/ready streams onto one
// output stream through a 2-entry (main + skid) output buffer. Every ready
// driven upstream is registered, so there is no combinational path from
// odata_rdy back to idata_rdy.
// Optional feature macro: STAR_ARB_LOCK_EN -- when defined, a grant is held
// until the end of a packet (ilast); when undefined, arbitration is per beat.
module star_rr_arb #(
    parameter int N_IN       = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_IN*DATA_WIDTH-1:0] idata,
    input  logic [N_IN-1:0]            idata_vld,
    output logic [N_IN-1:0]            idata_rdy,
    input  logic [N_IN-1:0]            ilast,
    output logic [DATA_WIDTH-1:0]      odata,
    output logic                       odata_vld,
    input  logic                       odata_rdy,
    output logic                       olast,
    output logic [SEL_WIDTH-1:0]       osel
);

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        XFER = 1'b1
    } state_t;

    // First requesting stream found searching upward from last+1, wrapping.
    function automatic logic [SEL_WIDTH-1:0] rr_pick(
        input logic [N_IN-1:0]      vld,
        input logic [SEL_WIDTH-1:0] last
    );
        logic [SEL_WIDTH-1:0] pick;
        logic [N_IN-1:0]      shifted;
        logic                 found;
        logic                 hit;
        int                   idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= N_IN; i++) begin
            idx     = (int'(last) + i) % N_IN;
            shifted = vld >> idx;
            hit     = ~found & shifted[0];
            pick    = hit ? SEL_WIDTH'(idx) : pick;
            found   = found | hit;
        end
        return pick;
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [SEL_WIDTH-1:0]    grant_r;
    logic [SEL_WIDTH-1:0]    grant_next_s;
    logic [SEL_WIDTH-1:0]    last_r;
    logic [SEL_WIDTH-1:0]    last_next_s;
    logic [SEL_WIDTH-1:0]    pick_s;

    logic                    skid_vld_r;
    logic                    skid_vld_next_s;
    logic [DATA_WIDTH-1:0]   skid_data_r;
    logic                    skid_last_r;
    logic [SEL_WIDTH-1:0]    skid_sel_r;

    logic                    xfer_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    main_load_s;
    logic                    skid_load_s;
    logic [DATA_WIDTH-1:0]   beat_data_s;
    logic                    beat_last_s;
    logic [N_IN-1:0]         rdy_next_s;
    logic [N_IN-1:0]         grant_onehot_s;

    assign pick_s      = rr_pick(idata_vld, last_r);
    assign beat_data_s = idata[grant_r*DATA_WIDTH +: DATA_WIDTH];
    assign beat_last_s = ilast[grant_r];
    // Ready is only ever set for the granted stream, so the handshake needs
    // no extra qualification beyond the FSM being in XFER.
    assign xfer_s      = (state_r == XFER) & idata_vld[grant_r] & idata_rdy[grant_r];
    assign push_s      = xfer_s;
    assign pop_s       = odata_vld & odata_rdy;
    // A push can only happen with the skid empty (ready is the registered
    // negation of skid occupancy), so main takes the beat whenever it frees.
    assign main_load_s = push_s & (~odata_vld | pop_s);
    assign skid_load_s = push_s & odata_vld & ~pop_s;

    // Next-state, grant and round-robin pointer selection.
    always_comb begin
        state_next_s = state_r;
        grant_next_s = grant_r;
        last_next_s  = last_r;
        case (state_r)
            ARB: begin
                if (|idata_vld) begin
                    grant_next_s = pick_s;
                    last_next_s  = pick_s;
                    state_next_s = XFER;
                end else begin
                    state_next_s = ARB;
                end
            end
            XFER: begin
                if (xfer_s) begin
`ifdef STAR_ARB_LOCK_EN
                    state_next_s = beat_last_s ? ARB : XFER;
`else
                    state_next_s = ARB;
`endif
                end else begin
                    state_next_s = XFER;
                end
            end
            default: begin
                state_next_s = ARB;
            end
        endcase
    end

    // Next skid occupancy and the registered per-stream ready it implies.
    always_comb begin
        skid_vld_next_s = skid_vld_r;
        rdy_next_s      = {N_IN{1'b0}};
        grant_onehot_s  = {{(N_IN-1){1'b0}}, 1'b1} << grant_next_s;
        if (skid_load_s) begin
            skid_vld_next_s = 1'b1;
        end else if (pop_s) begin
            skid_vld_next_s = 1'b0;
        end else begin
            skid_vld_next_s = skid_vld_r;
        end
        if ((state_next_s == XFER) && !skid_vld_next_s) begin
            rdy_next_s = grant_onehot_s;
        end else begin
            rdy_next_s = {N_IN{1'b0}};
        end
    end

    // FSM, grant, round-robin pointer and ready registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ARB;
            grant_r   <= {SEL_WIDTH{1'b0}};
            last_r    <= SEL_WIDTH'(N_IN - 1);
            idata_rdy <= {N_IN{1'b0}};
        end else begin
            state_r   <= state_next_s;
            grant_r   <= grant_next_s;
            last_r    <= last_next_s;
            idata_rdy <= rdy_next_s;
        end
    end

    // Main output entry: loads a fresh beat, refills from skid, or empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            odata_vld <= 1'b0;
            odata     <= {DATA_WIDTH{1'b0}};
            olast     <= 1'b0;
            osel      <= {SEL_WIDTH{1'b0}};
        end else if (main_load_s) begin
            odata_vld <= 1'b1;
            odata     <= beat_data_s;
            olast     <= beat_last_s;
            osel      <= grant_r;
        end else if (pop_s && skid_vld_r) begin
            odata_vld <= 1'b1;
            odata     <= skid_data_r;
            olast     <= skid_last_r;
            osel      <= skid_sel_r;
        end else if (pop_s) begin
            odata_vld <= 1'b0;
        end
    end

    // Skid entry: catches a beat that arrives while main is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_vld_r  <= 1'b0;
            skid_data_r <= {DATA_WIDTH{1'b0}};
            skid_last_r <= 1'b0;
            skid_sel_r  <= {SEL_WIDTH{1'b0}};
        end else begin
            skid_vld_r <= skid_vld_next_s;
            if (skid_load_s) begin
                skid_data_r <= beat_data_s;
                skid_last_r <= beat_last_s;
                skid_sel_r  <= grant_r;
            end
        end
    end

endmodule

// File: tb/tb_star_rr_arb.sv
// Directed, self-checking bench for star_rr_arb (4 streams, 8-bit data).
// Expected results for the lock/per-beat scenario follow STAR_ARB_LOCK_EN.
module tb_star_rr_arb;

    localparam int N_IN       = 4;
    localparam int SEL_WIDTH  = 2;
    localparam int DATA_WIDTH = 8;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [N_IN*DATA_WIDTH-1:0] idata;
    logic [N_IN-1:0]            idata_vld;
    logic [N_IN-1:0]            idata_rdy;
    logic [N_IN-1:0]            ilast;
    logic [DATA_WIDTH-1:0]      odata;
    logic                       odata_vld;
    logic                       odata_rdy;
    logic                       olast;
    logic [SEL_WIDTH-1:0]       osel;

    int n_checks;
    int n_pass;
    int in_cnt;

    logic [7:0] oq_data [$];
    logic       oq_last [$];
    logic [1:0] oq_sel  [$];

    logic [7:0] src_data [4][8];
    logic       src_last [4][8];
    int         src_len  [4];
    int         src_idx  [4];
    bit         src_en;

    star_rr_arb #(
        .N_IN      (N_IN),
        .SEL_WIDTH (SEL_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .idata    (idata),
        .idata_vld(idata_vld),
        .idata_rdy(idata_rdy),
        .ilast    (ilast),
        .odata    (odata),
        .odata_vld(odata_vld),
        .odata_rdy(odata_rdy),
        .olast    (olast),
        .osel     (osel)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_sources();
        for (int i = 0; i < N_IN; i++) begin
            if (src_idx[i] < src_len[i]) begin
                idata[i*DATA_WIDTH +: DATA_WIDTH] = src_data[i][src_idx[i]];
                idata_vld[i] = 1'b1;
                ilast[i]     = src_last[i][src_idx[i]];
            end else begin
                idata[i*DATA_WIDTH +: DATA_WIDTH] = 8'h00;
                idata_vld[i] = 1'b0;
                ilast[i]     = 1'b0;
            end
        end
    endtask

    // One clock: record handshakes at the falling edge, then step past the
    // rising edge and advance any source whose beat was just accepted.
    task automatic tick();
        logic [N_IN-1:0] hs;
        @(negedge clk);
        hs = idata_vld & idata_rdy;
        in_cnt += $countones(hs);
        if (odata_vld && odata_rdy) begin
            oq_data.push_back(odata);
            oq_last.push_back(olast);
            oq_sel.push_back(osel);
        end
        @(posedge clk);
        #1;
        if (src_en) begin
            for (int i = 0; i < N_IN; i++) begin
                if (hs[i]) src_idx[i]++;
            end
            drive_sources();
        end
    endtask

    task automatic wait_out(input int n, input int budget, output int used);
        used = 0;
        while (oq_data.size() < n && used < budget) begin
            tick();
            used++;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        src_en    = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            src_len[i] = 0;
            src_idx[i] = 0;
        end
        idata     = '0;
        idata_vld = 4'b0000;
        ilast     = 4'b0000;
        odata_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        oq_data.delete();
        oq_last.delete();
        oq_sel.delete();
        in_cnt = 0;
    endtask

    task automatic test_reset();
        int used;
        do_reset();
        rst = 1'b1;
        tick();
        n_checks++;
        if (idata_rdy !== 4'b0000 || odata_vld !== 1'b0 || odata !== 8'h00 ||
            olast !== 1'b0 || osel !== 2'd0)
            $display("FAIL reset_values: rdy=%b vld=%b data=%h last=%b sel=%0d, want all zero",
                     idata_rdy, odata_vld, odata, olast, osel);
        else n_pass++;
        rst = 1'b0;
        in_cnt = 0;
        // Fill the buffer with two beats under backpressure.
        idata     = {8'h40, 8'h30, 8'h20, 8'h10};
        idata_vld = 4'b1111;
        ilast     = 4'b1111;
        odata_rdy = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        n_checks++;
        if (in_cnt !== 2) $display("FAIL reset_prefill_count: got %0d want 2", in_cnt);
        else n_pass++;
        n_checks++;
        if (odata_vld !== 1'b1) $display("FAIL reset_prefill_vld: got %b want 1", odata_vld);
        else n_pass++;
        // Asynchronous reset in the middle of the cycle.
        rst = 1'b1;
        #1;
        n_checks++;
        if (odata_vld !== 1'b0 || idata_rdy !== 4'b0000)
            $display("FAIL reset_async: vld=%b rdy=%b want 0/0000", odata_vld, idata_rdy);
        else n_pass++;
        tick();
        rst = 1'b0;
        oq_data.delete();
        oq_last.delete();
        oq_sel.delete();
        odata_rdy = 1'b1;
        wait_out(1, 20, used);
        n_checks++;
        if (oq_data.size() < 1) $display("FAIL reset_first_timeout: got %0d beats want 1", oq_data.size());
        else n_pass++;
        n_checks++;
        if (oq_data.size() < 1 || oq_data[0] !== 8'h10 || oq_sel[0] !== 2'd0)
            $display("FAIL reset_first_grant: got data/sel %h/%0d want 10/0",
                     (oq_data.size() > 0) ? oq_data[0] : 8'hxx, (oq_sel.size() > 0) ? oq_sel[0] : 2'bxx);
        else n_pass++;
    endtask

    task automatic test_fairness();
        int used;
        int cnt [4];
        do_reset();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        idata     = {8'h40, 8'h30, 8'h20, 8'h10};
        idata_vld = 4'b1111;
        ilast     = 4'b1111;
        odata_rdy = 1'b1;
        wait_out(8, 60, used);
        n_checks++;
        if (used !== 17) $display("FAIL fair_cycles: got %0d cycles want 17", used);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (i >= oq_data.size() || oq_sel[i] !== 2'(i % 4) ||
                oq_data[i] !== 8'(8'h10 * (i % 4 + 1)) || oq_last[i] !== 1'b1)
                $display("FAIL fair_beat%0d: got sel/data %0d/%h want %0d/%h", i,
                         (i < oq_sel.size()) ? oq_sel[i] : 2'bxx,
                         (i < oq_data.size()) ? oq_data[i] : 8'hxx,
                         i % 4, 8'(8'h10 * (i % 4 + 1)));
            else n_pass++;
            if (i < oq_sel.size()) cnt[oq_sel[i]]++;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cnt[i] !== 2) $display("FAIL fair_share%0d: got %0d beats want 2", i, cnt[i]);
            else n_pass++;
        end
        idata_vld = 4'b0000;
    endtask

    task automatic test_lock_mode();
        int used;
        logic [7:0] exp_d [6];
        logic [1:0] exp_s [6];
        logic       exp_l [6];
`ifdef STAR_ARB_LOCK_EN
        exp_d = '{8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h33};
        exp_s = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
        exp_d = '{8'h21, 8'h31, 8'h22, 8'h32, 8'h23, 8'h33};
        exp_s = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
        do_reset();
        src_data[1][0] = 8'h21; src_last[1][0] = 1'b0;
        src_data[1][1] = 8'h22; src_last[1][1] = 1'b0;
        src_data[1][2] = 8'h23; src_last[1][2] = 1'b1;
        src_data[2][0] = 8'h31; src_last[2][0] = 1'b0;
        src_data[2][1] = 8'h32; src_last[2][1] = 1'b0;
        src_data[2][2] = 8'h33; src_last[2][2] = 1'b1;
        src_len[1] = 3;
        src_len[2] = 3;
        src_en = 1'b1;
        drive_sources();
        odata_rdy = 1'b1;
        wait_out(6, 60, used);
        for (int k = 0; k < 4; k++) tick();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= oq_data.size() || oq_data[i] !== exp_d[i] ||
                oq_sel[i] !== exp_s[i] || oq_last[i] !== exp_l[i])
                $display("FAIL pkt_beat%0d: got data/sel/last %h/%0d/%b want %h/%0d/%b", i,
                         (i < oq_data.size()) ? oq_data[i] : 8'hxx,
                         (i < oq_sel.size()) ? oq_sel[i] : 2'bxx,
                         (i < oq_last.size()) ? oq_last[i] : 1'bx,
                         exp_d[i], exp_s[i], exp_l[i]);
            else n_pass++;
        end
        n_checks++;
        if (oq_data.size() !== 6 || in_cnt !== 6)
            $display("FAIL pkt_count: got out=%0d in=%0d want 6/6", oq_data.size(), in_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int used;
        do_reset();
        for (int j = 0; j < 6; j++) begin
            src_data[0][j] = 8'(j + 1);
            src_last[0][j] = 1'b1;
        end
        src_len[0] = 6;
        src_en = 1'b1;
        drive_sources();
        odata_rdy = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        n_checks++;
        if (in_cnt !== 2) $display("FAIL bp_accepted: got %0d want 2", in_cnt);
        else n_pass++;
        n_checks++;
        if (idata_rdy !== 4'b0000) $display("FAIL bp_rdy_drop: got %b want 0000", idata_rdy);
        else n_pass++;
        n_checks++;
        if (odata_vld !== 1'b1 || odata !== 8'h01 || osel !== 2'd0)
            $display("FAIL bp_head: got vld/data/sel %b/%h/%0d want 1/01/0", odata_vld, odata, osel);
        else n_pass++;
        odata_rdy = 1'b1;
        wait_out(6, 60, used);
        for (int k = 0; k < 5; k++) tick();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= oq_data.size() || oq_data[i] !== 8'(i + 1) || oq_sel[i] !== 2'd0)
                $display("FAIL bp_order%0d: got data/sel %h/%0d want %h/0", i,
                         (i < oq_data.size()) ? oq_data[i] : 8'hxx,
                         (i < oq_sel.size()) ? oq_sel[i] : 2'bxx, 8'(i + 1));
            else n_pass++;
        end
        n_checks++;
        if (oq_data.size() !== 6 || in_cnt !== 6)
            $display("FAIL bp_no_dup: got out=%0d in=%0d want 6/6", oq_data.size(), in_cnt);
        else n_pass++;
    endtask

    task automatic test_sparse();
        do_reset();
        odata_rdy = 1'b1;
        idata     = {8'h3F, 8'h00, 8'h00, 8'h00};
        idata_vld = 4'b1000;
        ilast     = 4'b1000;
        tick();
        n_checks++;
        if (idata_rdy !== 4'b1000 || odata_vld !== 1'b0)
            $display("FAIL sparse_grant: got rdy/vld %b/%b want 1000/0", idata_rdy, odata_vld);
        else n_pass++;
        tick();
        n_checks++;
        if (odata_vld !== 1'b1 || odata !== 8'h3F || osel !== 2'd3 || olast !== 1'b1)
            $display("FAIL sparse_data: got vld/data/sel/last %b/%h/%0d/%b want 1/3f/3/1",
                     odata_vld, odata, osel, olast);
        else n_pass++;
        n_checks++;
        if (idata_rdy !== 4'b0000) $display("FAIL sparse_rdy_after: got %b want 0000", idata_rdy);
        else n_pass++;
        idata_vld = 4'b0000;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        in_cnt   = 0;
        rst      = 1'b1;
        src_en   = 1'b0;
        idata     = '0;
        idata_vld = 4'b0000;
        ilast     = 4'b0000;
        odata_rdy = 1'b0;
        test_reset();
        test_fairness();
        test_lock_mode();
        test_backpressure();
        test_sparse();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
